l3_cache: RTL and testbench

- Last-level, single-outstanding-request cache; the responder on the L2 miss path.
- Accepts one read or write request from L2 via a valid/ready handshake and returns a one-cycle response pulse whose data drives L2's l3 valid/data fill inputs.
- 2-way set-associative, one word per line, write-through with no write-allocate, MRU-bit replacement.
- Backed by a variable-latency main-memory port.

---
 rtl/l3_cache.sv | 193 +++++++++++++++++++
 tb/tb_l3_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/l3_cache.sv
// rtl/l3_cache.sv - 2-way set-associative write-through last-level cache with a variable-latency memory port
module l3_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 1024,
  parameter int BLOCK_SIZE = 4,
  parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(NUM_SETS) - $clog2(BLOCK_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wr_data_i,
  input  logic [3:0]            req_byte_en_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_hit_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESPOND} state_t;

  state_t state;

  // Registered copy of the accepted request; all lookups use this copy.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;

  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  hit_q;

  // Data and tag arrays are left unreset so they can map onto RAM.
  logic [DATA_WIDTH-1:0] data_way0 [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_way1 [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tag_way0  [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tag_way1  [NUM_SETS];
  logic [NUM_SETS-1:0]   valid0;
  logic [NUM_SETS-1:0]   valid1;
  logic [NUM_SETS-1:0]   mru;

  logic [IDX_W-1:0]      idx;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  hit0;
  logic                  hit1;
  logic                  hit;
  logic                  hit_way;
  logic                  victim;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  fill_en;
  logic                  merge_en;

  // Tag compare, victim choice and byte merge for the registered request.
  always_comb begin
    idx      = addr_q[OFF_W +: IDX_W];
    tag      = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    hit0     = valid0[idx] && (tag_way0[idx] == tag);
    hit1     = valid1[idx] && (tag_way1[idx] == tag);
    hit      = hit0 || hit1;
    hit_way  = !hit0 && hit1;
    hit_word = hit_way ? data_way1[idx] : data_way0[idx];
    if (!valid0[idx]) begin
      victim = 1'b0;
    end else if (!valid1[idx]) begin
      victim = 1'b1;
    end else begin
      victim = !mru[idx];
    end
    merged = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) begin
        merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
    fill_en  = (state == MEM_RD) && mem_valid_i;
    merge_en = (state == LOOKUP) && wr_q && hit;
  end

  // Array writes: line fill on a read-miss ack, byte merge on a write hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        data_way1[idx] <= mem_rd_data_i;
        tag_way1[idx]  <= tag;
      end else begin
        data_way0[idx] <= mem_rd_data_i;
        tag_way0[idx]  <= tag;
      end
    end
    if (merge_en) begin
      if (hit_way) begin
        data_way1[idx] <= merged;
      end else begin
        data_way0[idx] <= merged;
      end
    end
  end

  // Request FSM with valid/MRU bookkeeping; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      resp_data_q <= '0;
      hit_q       <= 1'b0;
      valid0      <= '0;
      valid1      <= '0;
      mru         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wr_q    <= req_wr_en_i;
            wdata_q <= req_wr_data_i;
            be_q    <= req_byte_en_i;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q       <= hit;
          resp_data_q <= '0;
          if (hit) begin
            mru[idx] <= hit_way;
          end
          if (wr_q) begin
            state <= MEM_WR;
          end else if (hit) begin
            resp_data_q <= hit_word;
            state       <= RESPOND;
          end else begin
            state <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_valid_i) begin
            if (victim) begin
              valid1[idx] <= 1'b1;
            end else begin
              valid0[idx] <= 1'b1;
            end
            mru[idx]    <= victim;
            resp_data_q <= mem_rd_data_i;
            state       <= RESPOND;
          end
        end
        MEM_WR: begin
          if (mem_valid_i) begin
            resp_data_q <= '0;
            state       <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decodes of state and registered request fields only.
  always_comb begin
    req_ready_o   = (state == IDLE);
    resp_valid_o  = (state == RESPOND);
    resp_data_o   = resp_valid_o ? resp_data_q : '0;
    resp_hit_o    = resp_valid_o && hit_q;
    mem_rd_en_o   = (state == MEM_RD);
    mem_wr_en_o   = (state == MEM_WR);
    mem_addr_o    = (state != IDLE) ? (addr_q & ~OFF_MASK) : '0;
    mem_wr_data_o = (state != IDLE) ? wdata_q : '0;
    mem_byte_en_o = (state != IDLE) ? be_q : '0;
  end

endmodule

// File: tb/tb_l3_cache.sv
// tb/tb_l3_cache.sv - directed self-checking bench for l3_cache
module tb_l3_cache;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_en_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wr_data_i;
  logic [3:0]  req_byte_en_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_hit_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_byte_en_o;
  logic        mem_valid_i;
  logic [31:0] mem_rd_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        h;
  int          ec;
  int          lt;

  l3_cache dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_wr_en_i   (req_wr_en_i),
    .req_addr_i    (req_addr_i),
    .req_wr_data_i (req_wr_data_i),
    .req_byte_en_i (req_byte_en_i),
    .resp_valid_o  (resp_valid_o),
    .resp_data_o   (resp_data_o),
    .resp_hit_o    (resp_hit_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_byte_en_o (mem_byte_en_o),
    .mem_valid_i   (mem_valid_i),
    .mem_rd_data_i (mem_rd_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: drive it, act as memory acking after ack_delay enable cycles, collect the response.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int ack_delay, input logic [31:0] mdata,
                     output logic [31:0] rdata, output logic hit, output int en_cyc, output int lat);
    logic done;
    done   = 1'b0;
    rdata  = '0;
    hit    = 1'b0;
    en_cyc = 0;
    lat    = 0;
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready_o}, 32'd1);
    req_valid_i   = 1'b1;
    req_wr_en_i   = wr;
    req_addr_i    = addr;
    req_wr_data_i = wdata;
    req_byte_en_i = be;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (k > 1) @(negedge clk);
      mem_valid_i = 1'b0;
      if (resp_valid_o) begin
        done  = 1'b1;
        rdata = resp_data_o;
        hit   = resp_hit_o;
        lat   = k;
      end else if (mem_rd_en_o || mem_wr_en_o) begin
        en_cyc++;
        chk("mem_dir", {30'b0, mem_wr_en_o, mem_rd_en_o}, wr ? 32'd2 : 32'd1);
        chk("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        if (wr) begin
          chk("mem_wr_data", mem_wr_data_o, wdata);
          chk("mem_byte_en", {28'b0, mem_byte_en_o}, {28'b0, be});
        end
        if (en_cyc == ack_delay) begin
          mem_valid_i   = 1'b1;
          mem_rd_data_i = mdata;
        end
      end
    end
    if (!done) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("resp_one_cycle", {31'b0, resp_valid_o}, 32'd0);
      chk("resp_data_idle", resp_data_o, 32'd0);
      chk("resp_hit_idle", {31'b0, resp_hit_o}, 32'd0);
      chk("mem_addr_idle", mem_addr_o, 32'd0);
      chk("ready_after", {31'b0, req_ready_o}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    req_valid_i   = 1'b0;
    req_wr_en_i   = 1'b0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    req_byte_en_i = '0;
    mem_valid_i   = 1'b0;
    mem_rd_data_i = '0;
    #1;
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_mem_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold read miss, memory acks after 3 enable cycles.
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 3, 32'hDEAD_BEEF, rd, h, ec, lt);
    chk("miss1_data", rd, 32'hDEAD_BEEF);
    chk("miss1_hit", {31'b0, h}, 32'd0);
    chk("miss1_en_cycles", ec, 32'd3);
    chk("miss1_latency", lt, 32'd5);

    // Re-read hits with no memory access.
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 1, 32'h0BAD_0BAD, rd, h, ec, lt);
    chk("hit1_data", rd, 32'hDEAD_BEEF);
    chk("hit1_hit", {31'b0, h}, 32'd1);
    chk("hit1_en_cycles", ec, 32'd0);
    chk("hit1_latency", lt, 32'd2);

    // Write hit with partial byte enables, written through to memory.
    txn(1'b1, 32'h0000_1000, 32'h1122_3344, 4'b0011, 2, 32'd0, rd, h, ec, lt);
    chk("wrhit_data", rd, 32'd0);
    chk("wrhit_hit", {31'b0, h}, 32'd1);
    chk("wrhit_en_cycles", ec, 32'd2);
    chk("wrhit_latency", lt, 32'd4);
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 1, 32'h0BAD_0BAD, rd, h, ec, lt);
    chk("merge_data", rd, 32'hDEAD_3344);
    chk("merge_hit", {31'b0, h}, 32'd1);
    chk("merge_en_cycles", ec, 32'd0);

    // Same-set conflict: 0x0010_1000 becomes LRU and is evicted by 0x0020_1000.
    txn(1'b0, 32'h0010_1000, 32'd0, 4'b0, 1, 32'hAAAA_0001, rd, h, ec, lt);
    chk("fill2_data", rd, 32'hAAAA_0001);
    chk("fill2_hit", {31'b0, h}, 32'd0);
    chk("fill2_latency", lt, 32'd3);
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 1, 32'h0BAD_0BAD, rd, h, ec, lt);
    chk("touch_hit", {31'b0, h}, 32'd1);
    chk("touch_data", rd, 32'hDEAD_3344);
    txn(1'b0, 32'h0020_1000, 32'd0, 4'b0, 1, 32'hBBBB_0002, rd, h, ec, lt);
    chk("fill3_hit", {31'b0, h}, 32'd0);
    chk("fill3_data", rd, 32'hBBBB_0002);
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 1, 32'h0BAD_0BAD, rd, h, ec, lt);
    chk("survivor_hit", {31'b0, h}, 32'd1);
    chk("survivor_data", rd, 32'hDEAD_3344);
    txn(1'b0, 32'h0010_1000, 32'd0, 4'b0, 1, 32'hAAAA_0001, rd, h, ec, lt);
    chk("evicted_hit", {31'b0, h}, 32'd0);
    chk("evicted_en_cycles", ec, 32'd1);

    // Write miss: no allocation, offset bits cleared on the memory address.
    txn(1'b1, 32'h0000_2002, 32'h5566_7788, 4'b1111, 1, 32'd0, rd, h, ec, lt);
    chk("wrmiss_hit", {31'b0, h}, 32'd0);
    chk("wrmiss_data", rd, 32'd0);
    chk("wrmiss_en_cycles", ec, 32'd1);
    txn(1'b0, 32'h0000_2000, 32'd0, 4'b0, 2, 32'hCCCC_0003, rd, h, ec, lt);
    chk("noalloc_hit", {31'b0, h}, 32'd0);
    chk("noalloc_data", rd, 32'hCCCC_0003);
    chk("noalloc_en_cycles", ec, 32'd2);

    // Reset in the middle of a read miss.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wr_en_i = 1'b0;
    req_addr_i  = 32'h0000_3000;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd_en", {31'b0, mem_rd_en_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("mid_rst_resp", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_resp", {31'b0, resp_valid_o}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
    end
    mem_valid_i   = 1'b1;
    mem_rd_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_valid_i = 1'b0;
    chk("late_ack_resp", {31'b0, resp_valid_o}, 32'd0);
    chk("late_ack_ready", {31'b0, req_ready_o}, 32'd1);
    chk("late_ack_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
    @(negedge clk);
    chk("late_ack_resp2", {31'b0, resp_valid_o}, 32'd0);
    txn(1'b0, 32'h0000_3000, 32'd0, 4'b0, 1, 32'h1234_5678, rd, h, ec, lt);
    chk("after_rst_hit", {31'b0, h}, 32'd0);
    chk("after_rst_data", rd, 32'h1234_5678);
    chk("after_rst_en_cycles", ec, 32'd1);
    txn(1'b0, 32'h0000_1000, 32'd0, 4'b0, 1, 32'h7777_0004, rd, h, ec, lt);
    chk("rst_cleared_hit", {31'b0, h}, 32'd0);
    chk("rst_cleared_data", rd, 32'h7777_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
